prga_decryptor: RTL and testbench

Pseudo-random generation and XOR stage of the RC4 datapath, directly downstream of the key-schedule shuffler. After the shuffler has permuted S-memory, this block runs the RC4 PRGA over S, reads each ciphertext byte from the encrypted-message ROM, and writes the XOR plaintext byte into the decrypted-message RAM. The top level muxes S-memory between the shuffler and this block and pulses `start` when the shuffler reports `finished`.

---
 rtl/rc4_pkg.sv | 26 ++
 rtl/prga_decryptor_if.sv | 30 +++
 rtl/edge_detector.sv | 24 ++
 rtl/prga_decryptor.sv | 145 ++++++++++++++
 tb/tb_prga_decryptor.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants: PRGA state encoding and the printable-ASCII
// window used by the optional plaintext check (PRGA_ASCII_CHECK_EN).
package rc4_pkg;

    typedef enum logic [3:0] {
        AWAIT_START,
        FETCH_SI,
        READ_SI,
        READ_SJ,
        WRITE_SI,
        WRITE_SJ,
        FETCH_F,
        READ_F,
        WRITE_D,
        FINISHED
    } prga_state_t;

    localparam logic [7:0] ASCII_LOWER_MIN = 8'h61;
    localparam logic [7:0] ASCII_LOWER_MAX = 8'h7A;
    localparam logic [7:0] ASCII_SPACE     = 8'h20;

    function automatic logic is_plain_ascii(input logic [7:0] b);
        return ((b >= ASCII_LOWER_MIN) && (b <= ASCII_LOWER_MAX)) || (b == ASCII_SPACE);
    endfunction

endpackage

// File: rtl/prga_decryptor_if.sv
// Memory-side bus of the PRGA stage: S-memory, ciphertext ROM and plaintext RAM ports.
interface prga_decryptor_if #(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_LENGTH     = 8,
    parameter int MSG_ADDR_WIDTH = 5
) ();

    logic [RAM_WIDTH-1:0]      s_ram_out;
    logic [RAM_LENGTH-1:0]     s_address;
    logic [RAM_WIDTH-1:0]      s_ram_in;
    logic                      s_write_enable;
    logic [RAM_WIDTH-1:0]      rom_out;
    logic [MSG_ADDR_WIDTH-1:0] rom_address;
    logic [MSG_ADDR_WIDTH-1:0] d_address;
    logic [RAM_WIDTH-1:0]      d_ram_in;
    logic                      d_write_enable;

    modport master (
        input  s_ram_out, rom_out,
        output s_address, s_ram_in, s_write_enable,
        output rom_address, d_address, d_ram_in, d_write_enable
    );

    modport slave (
        output s_ram_out, rom_out,
        input  s_address, s_ram_in, s_write_enable,
        input  rom_address, d_address, d_ram_in, d_write_enable
    );

endinterface

// File: rtl/edge_detector.sv
// Rising-edge detector: registers the input once more so a held level yields a single pulse.
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q    <= 1'b0;
            sig_prev <= 1'b0;
        end else begin
            sig_q    <= sig;
            sig_prev <= sig_q;
        end
    end

    assign rise = sig_q & ~sig_prev;

endmodule

// File: rtl/prga_decryptor.sv
// RC4 PRGA + XOR stage: walks S, swaps, and writes ciphertext ^ keystream to the plaintext RAM.
// Optional PRGA_ASCII_CHECK_EN adds `invalid` and stops early on a non-printable byte.
module prga_decryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_LENGTH     = 8,
    parameter int MSG_LENGTH     = 32,
    parameter int MSG_ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             finished,
    prga_decryptor_if.master bus
`ifdef PRGA_ASCII_CHECK_EN
    ,
    output logic             invalid
`endif
);

    prga_state_t state, state_next;

    logic                      start_rise;
    logic [RAM_LENGTH-1:0]     i, j;
    logic [MSG_ADDR_WIDTH-1:0] k;
    logic [RAM_WIDTH-1:0]      si, sj, f, enc;
    logic [RAM_WIDTH-1:0]      plain;
    logic                      last_byte;
    logic                      abort;

    edge_detector u_start_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (start),
        .rise  (start_rise)
    );

    assign plain     = f ^ enc;
    assign last_byte = (k == MSG_ADDR_WIDTH'(MSG_LENGTH - 1));

`ifdef PRGA_ASCII_CHECK_EN
    assign abort = ~is_plain_ascii(plain);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  invalid <= 1'b0;
        else if (state == AWAIT_START && start_rise) invalid <= 1'b0;
        else if (state == WRITE_D && abort)          invalid <= 1'b1;
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= AWAIT_START;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            AWAIT_START: if (start_rise) state_next = FETCH_SI;
            FETCH_SI:    state_next = READ_SI;
            READ_SI:     state_next = READ_SJ;
            READ_SJ:     state_next = WRITE_SI;
            WRITE_SI:    state_next = WRITE_SJ;
            WRITE_SJ:    state_next = FETCH_F;
            FETCH_F:     state_next = READ_F;
            READ_F:      state_next = WRITE_D;
            WRITE_D:     state_next = (last_byte || abort) ? FINISHED : FETCH_SI;
            FINISHED:    state_next = AWAIT_START;
            default:     state_next = AWAIT_START;
        endcase
    end

    // Addresses are driven combinationally so read data lands exactly one cycle later.
    always_comb begin
        finished           = 1'b0;
        bus.s_address      = '0;
        bus.s_ram_in       = '0;
        bus.s_write_enable = 1'b0;
        bus.rom_address    = '0;
        bus.d_address      = '0;
        bus.d_ram_in       = '0;
        bus.d_write_enable = 1'b0;
        case (state)
            FETCH_SI: bus.s_address = i + RAM_LENGTH'(1);
            READ_SI:  bus.s_address = j + RAM_LENGTH'(bus.s_ram_out);
            WRITE_SI: begin
                bus.s_address      = i;
                bus.s_ram_in       = sj;
                bus.s_write_enable = 1'b1;
            end
            WRITE_SJ: begin
                bus.s_address      = j;
                bus.s_ram_in       = si;
                bus.s_write_enable = 1'b1;
            end
            FETCH_F: begin
                bus.s_address   = RAM_LENGTH'(RAM_WIDTH'(si + sj));
                bus.rom_address = k;
            end
            WRITE_D: begin
                bus.d_address      = k;
                bus.d_ram_in       = plain;
                bus.d_write_enable = 1'b1;
            end
            FINISHED: finished = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            si  <= '0;
            sj  <= '0;
            f   <= '0;
            enc <= '0;
        end else begin
            case (state)
                AWAIT_START: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
                FETCH_SI: i <= i + RAM_LENGTH'(1);
                READ_SI: begin
                    si <= bus.s_ram_out;
                    j  <= j + RAM_LENGTH'(bus.s_ram_out);
                end
                READ_SJ: sj <= bus.s_ram_out;
                READ_F: begin
                    f   <= bus.s_ram_out;
                    enc <= bus.rom_out;
                end
                WRITE_D: if (!last_byte && !abort) k <= k + MSG_ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decryptor.sv
// Bench for prga_decryptor: synchronous memory models plus a plain RC4 reference model.
module tb_prga_decryptor;

    localparam int RW  = 8;
    localparam int RL  = 8;
    localparam int ML  = 32;
    localparam int MAW = 5;
    localparam int RUN_FIN_SAMPLE = 1 + 8 * ML;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic finished;
`ifdef PRGA_ASCII_CHECK_EN
    logic invalid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic [7:0] m_s    [256];
    logic [7:0] m_save [256];
    logic [7:0] rom    [ML];
    logic [7:0] d_mem  [ML];
    logic [7:0] exp_d  [ML];
    logic [7:0] ks     [ML];
    logic [7:0] plain  [ML];
    logic       load_s  = 1'b0;
    logic       clear_d = 1'b0;

    prga_decryptor_if #(.RAM_WIDTH(RW), .RAM_LENGTH(RL), .MSG_ADDR_WIDTH(MAW)) bus ();

    prga_decryptor #(
        .RAM_WIDTH(RW), .RAM_LENGTH(RL), .MSG_LENGTH(ML), .MSG_ADDR_WIDTH(MAW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .finished (finished),
        .bus      (bus)
`ifdef PRGA_ASCII_CHECK_EN
        ,
        .invalid  (invalid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_s) s_mem <= s_init;
        else if (bus.s_write_enable) s_mem[bus.s_address] <= bus.s_ram_in;
        if (clear_d) d_mem <= '{default: 8'h00};
        else if (bus.d_write_enable) d_mem[bus.d_address] <= bus.d_ram_in;
        bus.s_ram_out <= s_mem[bus.s_address];
        bus.rom_out   <= rom[bus.rom_address];
    end

    // RC4 PRGA over m_s with fresh i=j=0; leaves the swapped S in m_s.
    task automatic model_run();
        logic [7:0] mi, mj, t, fi;
        mi = 8'd0;
        mj = 8'd0;
        for (int n = 0; n < ML; n++) begin
            mi = mi + 8'd1;
            mj = mj + m_s[mi];
            t = m_s[mi];
            m_s[mi] = m_s[mj];
            m_s[mj] = t;
            fi = m_s[mi] + m_s[mj];
            exp_d[n] = m_s[fi] ^ rom[n];
        end
    endtask

    // Fills rom so that the current S decrypts to random lowercase/space text.
    task automatic make_ascii_rom();
        int r;
        m_save = m_s;
        for (int n = 0; n < ML; n++) rom[n] = 8'h00;
        model_run();
        ks = exp_d;
        m_s = m_save;
        for (int n = 0; n < ML; n++) begin
            r = $urandom_range(0, 26);
            plain[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            rom[n] = plain[n] ^ ks[n];
        end
    endtask

    task automatic load_mem(input bit reload_s);
        @(negedge clk);
        s_init  = m_s;
        load_s  = reload_s;
        clear_d = 1'b1;
        @(negedge clk);
        load_s  = 1'b0;
        clear_d = 1'b0;
    endtask

    // Sample m is taken at the negedge after the m-th posedge following the start-sampling edge.
    task automatic run_capture(input int hold, input int budget, output int first_fin,
                               output int n_fin, output int n_dwe, output int n_swe);
        first_fin = -1;
        n_fin = 0;
        n_dwe = 0;
        n_swe = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int m = 0; m < budget; m++) begin
            @(negedge clk);
            if (m + 1 >= hold) start = 1'b0;
            if (finished === 1'b1) begin
                n_fin++;
                if (first_fin < 0) first_fin = m;
            end
            if (bus.d_write_enable === 1'b1) n_dwe++;
            if (bus.s_write_enable === 1'b1) n_swe++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] outs;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        outs = {finished, bus.s_write_enable, bus.d_write_enable, bus.s_address, bus.s_ram_in,
                bus.rom_address, bus.d_address, bus.d_ram_in};
        n_cmp++;
        if (outs !== 48'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
`ifdef PRGA_ASCII_CHECK_EN
        n_cmp++;
        if (invalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_invalid: got %b expected 0", invalid);
        end
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_identity();
        int ff, nf, nd, ns;
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
        make_ascii_rom();
        rom[0] = 8'h63;
        rom[1] = 8'h64;
        load_mem(1'b1);
        model_run();
        run_capture(1, RUN_FIN_SAMPLE + 20, ff, nf, nd, ns);
        n_cmp++;
        if (ff !== RUN_FIN_SAMPLE) begin n_bad++; $display("FAIL ident_fin_time: got %0d expected %0d", ff, RUN_FIN_SAMPLE); end
        n_cmp++;
        if (nf !== 1) begin n_bad++; $display("FAIL ident_fin_count: got %0d expected 1", nf); end
        n_cmp++;
        if (nd !== ML) begin n_bad++; $display("FAIL ident_d_strobes: got %0d expected %0d", nd, ML); end
        n_cmp++;
        if (ns !== 2 * ML) begin n_bad++; $display("FAIL ident_s_strobes: got %0d expected %0d", ns, 2 * ML); end
        n_cmp++;
        if (d_mem[0] !== 8'h61) begin n_bad++; $display("FAIL ident_d0: got %h expected 61", d_mem[0]); end
        n_cmp++;
        if (d_mem[1] !== 8'h61) begin n_bad++; $display("FAIL ident_d1: got %h expected 61", d_mem[1]); end
        for (int n = 0; n < ML; n++) begin
            n_cmp++;
            if (d_mem[n] !== exp_d[n]) begin
                n_bad++;
                $display("FAIL ident_d[%0d]: got %h expected %h", n, d_mem[n], exp_d[n]);
            end
        end
        n_cmp++;
        if (s_mem != m_s) begin n_bad++; $display("FAIL ident_s_final: S memory differs from model"); end
    endtask

    task automatic test_start_held();
        int ff, nf, nd, ns;
        make_ascii_rom();
        load_mem(1'b0);
        model_run();
        run_capture(500, 520, ff, nf, nd, ns);
        n_cmp++;
        if (nf !== 1) begin n_bad++; $display("FAIL held_fin_count: got %0d expected 1", nf); end
        n_cmp++;
        if (ff !== RUN_FIN_SAMPLE) begin n_bad++; $display("FAIL held_fin_time: got %0d expected %0d", ff, RUN_FIN_SAMPLE); end
        for (int n = 0; n < ML; n++) begin
            n_cmp++;
            if (d_mem[n] !== exp_d[n]) begin
                n_bad++;
                $display("FAIL held_d[%0d]: got %h expected %h", n, d_mem[n], exp_d[n]);
            end
        end
        make_ascii_rom();
        load_mem(1'b0);
        model_run();
        run_capture(1, RUN_FIN_SAMPLE + 20, ff, nf, nd, ns);
        n_cmp++;
        if (nf !== 1) begin n_bad++; $display("FAIL rerun_fin_count: got %0d expected 1", nf); end
        for (int n = 0; n < ML; n++) begin
            n_cmp++;
            if (d_mem[n] !== exp_d[n]) begin
                n_bad++;
                $display("FAIL rerun_d[%0d]: got %h expected %h", n, d_mem[n], exp_d[n]);
            end
        end
        n_cmp++;
        if (s_mem != m_s) begin n_bad++; $display("FAIL rerun_s_final: S memory differs from model"); end
    endtask

    task automatic test_reset_mid_run();
        int ff, nf, nd, ns, late_fin;
        logic [46:0] outs;
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
        make_ascii_rom();
        load_mem(1'b1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= 45; m++) begin
            @(negedge clk);
            if (m == 0) start = 1'b0;
        end
        n_cmp++;
        if (bus.s_write_enable !== 1'b1) begin n_bad++; $display("FAIL midrst_in_write_sj: s_write_enable got %b expected 1", bus.s_write_enable); end
        reset = 1'b0;
        #1;
        outs = {bus.s_write_enable, bus.d_write_enable, bus.s_address, bus.s_ram_in,
                bus.rom_address, bus.d_address, bus.d_ram_in};
        n_cmp++;
        if ({finished, outs} !== 48'h0) begin n_bad++; $display("FAIL midrst_outputs: got %h expected 0", {finished, outs}); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        late_fin = 0;
        for (int m = 0; m < 300; m++) begin
            @(negedge clk);
            if (finished === 1'b1) late_fin++;
        end
        n_cmp++;
        if (late_fin !== 0) begin n_bad++; $display("FAIL midrst_no_finish: got %0d pulses expected 0", late_fin); end
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
        make_ascii_rom();
        load_mem(1'b1);
        model_run();
        run_capture(1, RUN_FIN_SAMPLE + 20, ff, nf, nd, ns);
        n_cmp++;
        if (ff !== RUN_FIN_SAMPLE) begin n_bad++; $display("FAIL midrst_rerun_fin_time: got %0d expected %0d", ff, RUN_FIN_SAMPLE); end
        for (int n = 0; n < ML; n++) begin
            n_cmp++;
            if (d_mem[n] !== exp_d[n]) begin
                n_bad++;
                $display("FAIL midrst_rerun_d[%0d]: got %h expected %h", n, d_mem[n], exp_d[n]);
            end
        end
    endtask

    task automatic test_ksa_key();
        int ff, nf, nd, ns;
        logic [7:0] key [3];
        logic [7:0] kj, t;
        key[0] = 8'h00;
        key[1] = 8'h02;
        key[2] = 8'h49;
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
        kj = 8'd0;
        for (int x = 0; x < 256; x++) begin
            kj = kj + m_s[x] + key[x % 3];
            t = m_s[x];
            m_s[x] = m_s[kj];
            m_s[kj] = t;
        end
        make_ascii_rom();
        load_mem(1'b1);
        model_run();
        run_capture(1, RUN_FIN_SAMPLE + 20, ff, nf, nd, ns);
        n_cmp++;
        if (nf !== 1) begin n_bad++; $display("FAIL ksa_fin_count: got %0d expected 1", nf); end
        for (int n = 0; n < ML; n++) begin
            n_cmp++;
            if (d_mem[n] !== plain[n]) begin
                n_bad++;
                $display("FAIL ksa_d[%0d]: got %h expected %h", n, d_mem[n], plain[n]);
            end
        end
    endtask

`ifdef PRGA_ASCII_CHECK_EN
    task automatic test_ascii_abort();
        int ff, nf, nd, ns;
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
        make_ascii_rom();
        rom[0] = 8'h00;
        load_mem(1'b1);
        run_capture(1, 40, ff, nf, nd, ns);
        n_cmp++;
        if (ff !== 9) begin n_bad++; $display("FAIL ascii_fin_time: got %0d expected 9", ff); end
        n_cmp++;
        if (nd !== 1) begin n_bad++; $display("FAIL ascii_d_strobes: got %0d expected 1", nd); end
        n_cmp++;
        if (d_mem[0] !== 8'h02) begin n_bad++; $display("FAIL ascii_d0: got %h expected 02", d_mem[0]); end
        n_cmp++;
        if (invalid !== 1'b1) begin n_bad++; $display("FAIL ascii_invalid: got %b expected 1", invalid); end
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_start_held();
        test_reset_mid_run();
        test_ksa_key();
`ifdef PRGA_ASCII_CHECK_EN
        test_ascii_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
